rbcp_wb_hub: RTL and testbench
==============================

RBCP_WB_HUB -- requirements
Module: rbcp_wb_hub

Interface
REQ-001 Parameter NUM_SLV, default 8: number of Wishbone slave ports, range 1..16.
REQ-002 Parameter SLV_BASE, default {NUM_SLV{16'h0}}: NUM_SLV*16-bit vector; slice k is the RBCP_ADDR[31:16] region code of slave k.
REQ-003 Parameter TMO_CYC, default 255: bus-phase timeout in CLK cycles, range 1..65535.
REQ-004 CLK  in  1  clock; reset RST, synchronous, active-high; clock CLK.
REQ-005 RST  in  1  synchronous active-high reset.
REQ-006 RBCP_ACT  in  1  RBCP session active.
REQ-007 RBCP_ADDR  in  32  RBCP byte address.
REQ-008 RBCP_WE / RBCP_RE  in  1 each  single-cycle write / read strobe.
REQ-009 RBCP_WD  in  8  write data.
REQ-010 RBCP_RD  out  8  read data, valid with RBCP_ACK.
REQ-011 RBCP_ACK  out  1  single-cycle acknowledge.
REQ-012 WB_CYC  out  1; WB_STB  out  NUM_SLV  one-hot per-slave strobe; WB_WE  out  1; WB_ADR  out  16 (RBCP_ADDR[15:0]); WB_DAT_O  out  8.
REQ-013 WB_DAT_I  in  NUM_SLV*8  slave k read data in bits [8k+7:8k]; WB_ACK  in  NUM_SLV  per-slave acknowledge.
REQ-014 ERR_CNT  out  8  saturating count of failed accesses (unmapped or timed out).

Function
REQ-015 FSM states: IDLE, BUS, RESP; IDLE on reset.
REQ-016 IDLE: a cycle with RBCP_ACT=1 and (RBCP_WE or RBCP_RE) registers address, WE, and WD, and decodes the region.
REQ-017 Decode: slave k hits when RBCP_ADDR[31:16]==SLV_BASE[k]; on multiple hits, the lowest index wins.
REQ-018 Hit: on the next cycle enter BUS with WB_CYC=1 and WB_STB[k]=1; all other STB bits stay 0.
REQ-019 Miss: enter RESP directly with RBCP_RD=8'h00; ERR_CNT increments.
REQ-020 BUS: on WB_ACK[k]=1, capture WB_DAT_I slice k (reads) or 8'h00 (writes), drop CYC/STB on the next edge, and enter RESP.
REQ-021 WB_ACK bits from non-selected slaves are ignored.
REQ-022 RESP: RBCP_ACK=1 for exactly one cycle with RBCP_RD valid, then return to IDLE.
REQ-023 Latency: strobe at cycle 0, STB high at cycle 1; an ack at cycle n gives RBCP_ACK at cycle n+1 (minimum 2). A miss gives RBCP_ACK at cycle 1.
REQ-024 RBCP_WE/RE arriving in BUS or RESP are ignored; no queuing.
REQ-025 RBCP_ACT falling in BUS: abort; CYC/STB drop on the next edge, no RBCP_ACK, return to IDLE, no ERR_CNT change.
REQ-026 RBCP_RD=8'h00 whenever RBCP_ACK=0.
REQ-027 ERR_CNT saturates at 8'hFF and does not wrap.

Reset
REQ-028 On the RST edge, all outputs go to 0 (RBCP_ACK, RBCP_RD, WB_CYC, WB_STB, WB_WE, WB_ADR, WB_DAT_O, ERR_CNT) and the FSM goes to IDLE, including mid-BUS; the aborted transaction never acknowledges.

Configuration
REQ-029 Macro RBCP_HUB_TIMEOUT_EN defined: a 16-bit counter runs in BUS. After TMO_CYC cycles without the selected ack, the hub drops CYC/STB, enters RESP with RBCP_RD=8'hEE, and increments ERR_CNT.
REQ-030 Macro RBCP_HUB_TIMEOUT_EN undefined: no counter; BUS waits indefinitely for ack or RBCP_ACT deassertion.

Structure
REQ-031 Package rbcp_hub_pkg holds the state enum and the constants TMO_RD_DATA=8'hEE, MISS_RD_DATA=8'h00, and REGION_W=16.
REQ-032 Sub-module rbcp_hub_decode: combinational region compare plus priority encoder, producing hit flag and one-hot select.

Verification
REQ-033 SLV_BASE[2]=16'h0003; read 0x0003_0012; slave 2 acks at cycle 3 with 8'h5A -> WB_ADR=16'h0012, STB=8'b0000_0100, RBCP_ACK at cycle 4 with RBCP_RD=8'h5A.
REQ-034 Write 0x0005_0000 (unmapped) -> no STB, RBCP_ACK at cycle 1 with RD=8'h00, ERR_CNT 0->1.
REQ-035 With RBCP_HUB_TIMEOUT_EN and TMO_CYC=10, read a mapped slave that never acks -> CYC drops after 10 BUS cycles, RBCP_ACK with RD=8'hEE, ERR_CNT+1.
REQ-036 SLV_BASE[1]=SLV_BASE[4]=16'h0002; write 0x0002_0001 WD=8'hC3 -> only STB[1], WB_DAT_O=8'hC3, WB_WE=1.
REQ-037 RBCP_ACT dropped at cycle 2 of BUS -> CYC=0 at cycle 3, no RBCP_ACK; a second RBCP_RE issued during BUS is ignored.
REQ-038 RST asserted mid-BUS -> all outputs 0 the next cycle; 300 forced misses -> ERR_CNT holds at 8'hFF.

Source files
------------

// File: rtl/rbcp_hub_pkg.sv
// Shared types and constants for the RBCP-to-Wishbone hub.
package rbcp_hub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } hub_state_e;

  localparam logic [7:0] TMO_RD_DATA  = 8'hEE;
  localparam logic [7:0] MISS_RD_DATA = 8'h00;
  localparam int         REGION_W     = 16;

  // Error counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rbcp_hub_decode.sv
// Region decoder: compares the RBCP region code against every slave base
// and picks the lowest matching index as a one-hot select.
module rbcp_hub_decode
  import rbcp_hub_pkg::*;
#(
  parameter int                            NUM_SLV  = 8,
  parameter logic [NUM_SLV*REGION_W-1:0]   SLV_BASE = {NUM_SLV{16'h0}}
) (
  input  logic [REGION_W-1:0] region,
  output logic                hit,
  output logic [NUM_SLV-1:0]  sel
);

  // Priority search: once a slave has matched, higher indices are ignored.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves it unassigned and a latch is never inferred.
    hit = 1'b0;
    sel = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (!hit && (region == SLV_BASE[k*REGION_W +: REGION_W])) begin
        hit    = 1'b1;
        sel[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rbcp_wb_hub.sv
// RBCP to multi-slave Wishbone hub. One RBCP access at a time is decoded to
// a slave by address region, run as a single Wishbone cycle and answered
// with a one-cycle RBCP_ACK. Failed accesses bump a saturating ERR_CNT.
// Optional: define RBCP_HUB_TIMEOUT_EN to abandon a bus phase that sees no
// acknowledge within TMO_CYC cycles (answered with read data 8'hEE).
module rbcp_wb_hub
  import rbcp_hub_pkg::*;
#(
  parameter int                            NUM_SLV  = 8,
  parameter logic [NUM_SLV*REGION_W-1:0]   SLV_BASE = {NUM_SLV{16'h0}},
  parameter int                            TMO_CYC  = 255
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RBCP_ACT,
  input  logic [31:0]            RBCP_ADDR,
  input  logic                   RBCP_WE,
  input  logic                   RBCP_RE,
  input  logic [7:0]             RBCP_WD,
  output logic [7:0]             RBCP_RD,
  output logic                   RBCP_ACK,
  output logic                   WB_CYC,
  output logic [NUM_SLV-1:0]     WB_STB,
  output logic                   WB_WE,
  output logic [15:0]            WB_ADR,
  output logic [7:0]             WB_DAT_O,
  input  logic [NUM_SLV*8-1:0]   WB_DAT_I,
  input  logic [NUM_SLV-1:0]     WB_ACK,
  output logic [7:0]             ERR_CNT
);

  hub_state_e           state_q, state_d;
  logic                 cyc_q, cyc_d;
  logic [NUM_SLV-1:0]   stb_q, stb_d;
  logic                 we_q, we_d;
  logic [15:0]          adr_q, adr_d;
  logic [7:0]           dato_q, dato_d;
  logic                 ack_q, ack_d;
  logic [7:0]           rd_q, rd_d;
  logic [7:0]           err_q, err_d;

  logic                 dec_hit;
  logic [NUM_SLV-1:0]   dec_sel;
  logic                 sel_ack;
  logic [7:0]           sel_dat;

  rbcp_hub_decode #(
    .NUM_SLV  (NUM_SLV),
    .SLV_BASE (SLV_BASE)
  ) u_decode (
    .region (RBCP_ADDR[31:16]),
    .hit    (dec_hit),
    .sel    (dec_sel)
  );

  // Only the acknowledge of the strobed slave counts; the rest are ignored.
  assign sel_ack = |(WB_ACK & stb_q);

  // Read-data mux driven by the registered one-hot strobe.
  always_comb begin
    sel_dat = '0;
    for (int k = 0; k < NUM_SLV; k++) begin
      if (stb_q[k]) sel_dat = sel_dat | WB_DAT_I[k*8 +: 8];
    end
  end

`ifdef RBCP_HUB_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);
  logic [15:0] tmo_q, tmo_d;
`else
  logic [15:0] unused_tmo;
  assign unused_tmo = 16'(TMO_CYC);
`endif

  // Next-state and next-output logic; all outputs are registered.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    stb_d   = stb_q;
    we_d    = we_q;
    adr_d   = adr_q;
    dato_d  = dato_q;
    ack_d   = 1'b0;
    rd_d    = 8'h00;
    err_d   = err_q;
`ifdef RBCP_HUB_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        if (RBCP_ACT && (RBCP_WE || RBCP_RE)) begin
          we_d   = RBCP_WE;
          adr_d  = RBCP_ADDR[15:0];
          dato_d = RBCP_WD;
          if (dec_hit) begin
            state_d = BUS;
            cyc_d   = 1'b1;
            stb_d   = dec_sel;
`ifdef RBCP_HUB_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end else begin
            state_d = RESP;
            ack_d   = 1'b1;
            rd_d    = MISS_RD_DATA;
            err_d   = sat_inc8(err_q);
          end
        end
      end
      BUS: begin
        // A dropped session wins over a coincident acknowledge.
        if (!RBCP_ACT) begin
          state_d = IDLE;
          cyc_d   = 1'b0;
          stb_d   = '0;
        end else if (sel_ack) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          stb_d   = '0;
          ack_d   = 1'b1;
          rd_d    = we_q ? 8'h00 : sel_dat;
        end
`ifdef RBCP_HUB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = RESP;
          cyc_d   = 1'b0;
          stb_d   = '0;
          ack_d   = 1'b1;
          rd_d    = TMO_RD_DATA;
          err_d   = sat_inc8(err_q);
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    if (RST) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dato_q  <= '0;
      ack_q   <= 1'b0;
      rd_q    <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      dato_q  <= dato_d;
      ack_q   <= ack_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
    end
  end

`ifdef RBCP_HUB_TIMEOUT_EN
  // Bus-phase cycle counter, cleared on every bus-phase entry.
  always_ff @(posedge CLK) begin
    if (RST) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign RBCP_ACK = ack_q;
  assign RBCP_RD  = rd_q;
  assign WB_CYC   = cyc_q;
  assign WB_STB   = stb_q;
  assign WB_WE    = we_q;
  assign WB_ADR   = adr_q;
  assign WB_DAT_O = dato_q;
  assign ERR_CNT  = err_q;

endmodule

// File: tb/tb_rbcp_wb_hub.sv
// Self-checking bench for rbcp_wb_hub: directed scenarios plus randomized
// accesses against a transaction-level model (region table + latency rules).
`timescale 1ns/1ps
module tb_rbcp_wb_hub;

  localparam int NUM_SLV = 8;
  localparam int TMO     = 10;
  localparam logic [NUM_SLV*16-1:0] BASE =
    {16'h0014, 16'h0013, 16'h0012, 16'h0002, 16'h0011, 16'h0003, 16'h0002, 16'h0010};
`ifdef RBCP_HUB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic                 CLK = 1'b0;
  logic                 RST;
  logic                 RBCP_ACT;
  logic [31:0]          RBCP_ADDR;
  logic                 RBCP_WE, RBCP_RE;
  logic [7:0]           RBCP_WD;
  logic [7:0]           RBCP_RD;
  logic                 RBCP_ACK;
  logic                 WB_CYC;
  logic [NUM_SLV-1:0]   WB_STB;
  logic                 WB_WE;
  logic [15:0]          WB_ADR;
  logic [7:0]           WB_DAT_O;
  logic [NUM_SLV*8-1:0] WB_DAT_I;
  logic [NUM_SLV-1:0]   WB_ACK;
  logic [7:0]           ERR_CNT;

  rbcp_wb_hub #(
    .NUM_SLV  (NUM_SLV),
    .SLV_BASE (BASE),
    .TMO_CYC  (TMO)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RBCP_ACT  (RBCP_ACT),
    .RBCP_ADDR (RBCP_ADDR),
    .RBCP_WE   (RBCP_WE),
    .RBCP_RE   (RBCP_RE),
    .RBCP_WD   (RBCP_WD),
    .RBCP_RD   (RBCP_RD),
    .RBCP_ACK  (RBCP_ACK),
    .WB_CYC    (WB_CYC),
    .WB_STB    (WB_STB),
    .WB_WE     (WB_WE),
    .WB_ADR    (WB_ADR),
    .WB_DAT_O  (WB_DAT_O),
    .WB_DAT_I  (WB_DAT_I),
    .WB_ACK    (WB_ACK),
    .ERR_CNT   (ERR_CNT)
  );

  always #5 CLK = ~CLK;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_err;

  // Reference address map: region code of each slave, in slave order.
  logic [15:0] region_tbl [NUM_SLV] =
    '{16'h0010, 16'h0002, 16'h0003, 16'h0011, 16'h0002, 16'h0012, 16'h0013, 16'h0014};
  logic [15:0] pick_tbl [9] =
    '{16'h0010, 16'h0002, 16'h0003, 16'h0011, 16'h0012, 16'h0013, 16'h0014, 16'h0005, 16'h0099};

  function automatic int lookup(input logic [15:0] region);
    for (int k = 0; k < NUM_SLV; k++) if (region_tbl[k] == region) return k;
    return -1;
  endfunction

  function automatic logic [7:0] sat_add(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'd1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Random slave activity: noise acks on other slaves, real ack optional.
  task automatic drive_slaves(input int sel, input bit ack_now, input logic [7:0] data);
    logic [NUM_SLV-1:0] a;
    a = NUM_SLV'($urandom);
    a[sel] = ack_now;
    WB_ACK = a;
    WB_DAT_I = {$urandom, $urandom};
    WB_DAT_I[sel*8 +: 8] = data;
  endtask

  // One complete RBCP access with all expectations derived from the model.
  task automatic txn(input logic [31:0] addr, input bit we, input logic [7:0] wd,
                     input int ack_cyc, input logic [7:0] data);
    int                 slv, eff;
    bit                 tmo;
    logic [7:0]         exp_rd;
    logic [NUM_SLV-1:0] exp_stb;
    slv = lookup(addr[31:16]);
    RBCP_ACT = 1'b1; RBCP_ADDR = addr; RBCP_WE = we; RBCP_RE = !we; RBCP_WD = wd;
    tick();
    RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    if (slv < 0) begin
      exp_err = sat_add(exp_err);
      check("miss_ack", RBCP_ACK, 1);
      check("miss_rd", RBCP_RD, 8'h00);
      check("miss_stb", WB_STB, 0);
      check("miss_err", ERR_CNT, exp_err);
    end else begin
      exp_stb = '0; exp_stb[slv] = 1'b1;
      tmo = TMO_EN && (ack_cyc > TMO);
      eff = tmo ? TMO : ack_cyc;
      for (int c = 1; c <= eff; c++) begin
        check("bus_cyc", WB_CYC, 1);
        check("bus_stb", WB_STB, exp_stb);
        check("bus_adr", WB_ADR, addr[15:0]);
        check("bus_we", WB_WE, we);
        if (we) check("bus_dato", WB_DAT_O, wd);
        check("bus_noack", RBCP_ACK, 0);
        check("bus_rd0", RBCP_RD, 8'h00);
        drive_slaves(slv, !tmo && (c == ack_cyc), data);
        tick();
      end
      WB_ACK = '0;
      if (tmo) begin
        exp_rd  = 8'hEE;
        exp_err = sat_add(exp_err);
      end else begin
        exp_rd = we ? 8'h00 : data;
      end
      check("resp_ack", RBCP_ACK, 1);
      check("resp_rd", RBCP_RD, exp_rd);
      check("resp_cyc", WB_CYC, 0);
      check("resp_stb", WB_STB, 0);
      check("resp_err", ERR_CNT, exp_err);
    end
    tick();
    check("post_ack", RBCP_ACK, 0);
    check("post_rd", RBCP_RD, 8'h00);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    RST = 1'b1; RBCP_ACT = 1'b0; RBCP_ADDR = '0; RBCP_WE = 1'b0; RBCP_RE = 1'b0;
    RBCP_WD = '0; WB_DAT_I = '0; WB_ACK = '0; exp_err = 8'h00;
    repeat (3) tick();
    RST = 1'b0;
    check("rst_ack", RBCP_ACK, 0);
    check("rst_rd", RBCP_RD, 0);
    check("rst_cyc", WB_CYC, 0);
    check("rst_stb", WB_STB, 0);
    check("rst_adr", WB_ADR, 0);
    check("rst_err", ERR_CNT, 0);

    // Strobe without an active session must not start anything.
    RBCP_ACT = 1'b0; RBCP_RE = 1'b1; RBCP_ADDR = 32'h0003_0000;
    tick();
    RBCP_RE = 1'b0;
    check("noact_cyc", WB_CYC, 0);
    check("noact_ack", RBCP_ACK, 0);

    // Read of slave 2 acked at cycle 3, response at cycle 4.
    txn(32'h0003_0012, 1'b0, 8'h00, 3, 8'h5A);
    // Unmapped write: immediate response, error count 0 -> 1.
    txn(32'h0005_0000, 1'b1, 8'h77, 0, 8'h00);
    // Shared region: lowest slave index (1) wins over slave 4.
    txn(32'h0002_0001, 1'b1, 8'hC3, 2, 8'h99);
    // Minimum latency and a long wait (times out when the timeout is built in).
    txn(32'h0010_ABCD, 1'b0, 8'h00, 1, 8'h81);
    txn(32'h0014_0007, 1'b0, 8'h00, 25, 8'h3C);

    // Session dropped during the bus phase, with a stray read strobe.
    RBCP_ACT = 1'b1; RBCP_ADDR = 32'h0003_0040; RBCP_RE = 1'b1;
    tick();
    check("abort_c1_cyc", WB_CYC, 1);
    check("abort_c1_stb", WB_STB, 8'b0000_0100);
    tick();
    RBCP_RE = 1'b0;
    check("abort_c2_cyc", WB_CYC, 1);
    check("abort_c2_adr", WB_ADR, 16'h0040);
    RBCP_ACT = 1'b0;
    tick();
    check("abort_c3_cyc", WB_CYC, 0);
    check("abort_c3_stb", WB_STB, 0);
    for (int i = 0; i < 3; i++) begin
      check("abort_noack", RBCP_ACK, 0);
      check("abort_err", ERR_CNT, exp_err);
      tick();
    end

    // Randomized accesses over mapped and unmapped regions.
    for (int i = 0; i < 40; i++) begin
      a = {pick_tbl[$urandom_range(0, 8)], 16'($urandom)};
      txn(a, 1'($urandom), 8'($urandom), $urandom_range(1, 6), 8'($urandom));
    end

    // Reset during the bus phase of a write to slave 1.
    RBCP_ACT = 1'b1; RBCP_ADDR = 32'h0002_0001; RBCP_WE = 1'b1; RBCP_WD = 8'hC3;
    tick();
    RBCP_WE = 1'b0;
    check("rstbus_stb", WB_STB, 8'b0000_0010);
    check("rstbus_dato", WB_DAT_O, 8'hC3);
    check("rstbus_we", WB_WE, 1);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    exp_err = 8'h00;
    check("rstbus_cyc", WB_CYC, 0);
    check("rstbus_stb0", WB_STB, 0);
    check("rstbus_we0", WB_WE, 0);
    check("rstbus_adr", WB_ADR, 0);
    check("rstbus_dato0", WB_DAT_O, 0);
    check("rstbus_ack", RBCP_ACK, 0);
    check("rstbus_rd", RBCP_RD, 0);
    check("rstbus_err", ERR_CNT, 0);
    WB_ACK = 8'b0000_0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rstbus_noack", RBCP_ACK, 0);
    end
    WB_ACK = '0;

    // Error counter saturation.
    for (int i = 0; i < 300; i++) txn(32'h0099_0000 | 32'(i), 1'($urandom), 8'h00, 0, 8'h00);
    check("sat_err", ERR_CNT, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
